// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Holds the FSM state encoding and the width helpers.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CW_DEF = $clog2(DW_DEF);

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// then trial-subtract the divisor.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   pr_in,
  input  logic          next_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   pr_out,
  output logic          q_bit
);

  logic [VW:0] shifted;
  logic [VW:0] dsr;

  assign shifted = {pr_in[VW-1:0], next_bit};
  assign dsr     = {1'b0, divisor};
  assign q_bit   = (shifted >= dsr);
  assign pr_out  = q_bit ? (shifted - dsr) : shifted;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock,
// behind a start/busy/done handshake.
import div_pkg::*;

module seq_divider #(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  localparam int CW = cnt_w(DW);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dsr;
  logic [VW:0]   pr;
  logic [VW:0]   pr_nxt;
  logic [DW-1:0] q;
  logic          q_bit;
  logic [CW-1:0] cnt;
  logic          dz;
  logic          last;

  assign last = (cnt == CW'(DW - 1));

  div_step #(
    .VW(VW)
  ) u_step (
    .pr_in   (pr),
    .next_bit(dvd[DW-1]),
    .divisor (dsr),
    .pr_out  (pr_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd         <= '0;
      dsr         <= '0;
      pr          <= '0;
      q           <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            pr          <= '0;
            cnt         <= '0;
            // zero divisor skips CALC; preload the saturated result
            if (divisor == '0) begin
              q  <= '1;
              dz <= 1'b1;
            end else begin
              q    <= '0;
              dz   <= 1'b0;
              dvd  <= dividend;
              dsr  <= divisor;
              busy <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd <= dvd << 1;
          pr  <= pr_nxt;
          q   <= {q[DW-2:0], q_bit};
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          quotient    <= q;
          remainder   <= pr[VW-1:0];
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive self-checking bench for seq_divider.
// Inputs change and outputs are sampled 1ns after each rising edge.
`timescale 1ns/1ps
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(
    .DW(8),
    .VW(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] a,
                     input logic [3:0] b, input logic [7:0] eq,
                     input logic [3:0] er, input logic ez,
                     input int elat);
    int lat;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    lat = 0;
    do begin
      if (lat > 0 || !done) begin
        tick();
        lat++;
      end
    end while (!done && lat < 20);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_by_zero, ez);
    if (!ez)
      chk({tag, "_inv"}, quotient * b + remainder, a);
  endtask

  initial begin : main
    bit seen;
    bit ok;
    int lat;
    logic [7:0] a;
    logic [3:0] b;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    // 120/12 with cycle-exact busy/done checks
    start    = 1'b1;
    dividend = 8'd120;
    divisor  = 4'd12;
    tick();
    start = 1'b0;
    chk("b0_busy", busy, 1);
    chk("b0_done", done, 0);
    ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
    end
    chk("b1_8_busy", ok, 1);
    tick();
    chk("e9_done", done, 1);
    chk("e9_busy", busy, 0);
    chk("e9_q", quotient, 10);
    chk("e9_r", remainder, 0);
    tick();
    chk("e10_done", done, 0);
    chk("e10_q", quotient, 10);

    run("d143", 8'd143, 4'd12, 8'd11, 4'd11, 1'b0, 9);
    run("d255", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9);
    run("d7", 8'd7, 4'd13, 8'd0, 4'd7, 1'b0, 9);
    run("z200", 8'd200, 4'd0, 8'hFF, 4'd0, 1'b1, 1);
    chk("z_busy", busy, 0);
    tick();
    run("d50", 8'd50, 4'd5, 8'd10, 4'd0, 1'b0, 9);

    // start pulses during CALC must be ignored
    start    = 1'b1;
    dividend = 8'd99;
    divisor  = 4'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    start    = 1'b1;
    dividend = 8'd10;
    divisor  = 4'd2;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 5;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk("ign_lat", lat, 9);
    chk("ign_q", quotient, 33);
    chk("ign_r", remainder, 0);
    repeat (3) tick();
    chk("ign_hold_q", quotient, 33);
    chk("ign_hold_busy", busy, 0);
    chk("ign_hold_done", done, 0);

    // reset in the middle of CALC
    start    = 1'b1;
    dividend = 8'd143;
    divisor  = 4'd12;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_q", quotient, 0);
    chk("mid_r", remainder, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_dz", div_by_zero, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("mid_no_done", seen, 0);
    run("d60", 8'd60, 4'd7, 8'd8, 4'd4, 1'b0, 9);

    // exhaustive back-to-back with start held high
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      for (int j = 1; j < 16; j++) begin
        a        = 8'(i);
        b        = 4'(j);
        dividend = a;
        divisor  = b;
        tick();
        lat = 0;
        while (!done && lat < 20) begin
          tick();
          lat++;
        end
        ok = (lat == 9) &&
             (16'(quotient) * 16'(b) + 16'(remainder) == 16'(a)) &&
             (remainder < b) && !div_by_zero;
        n_tests++;
        assert (ok) else begin
          n_fail++;
          $error("FAIL exh %0d/%0d: got q=%0d r=%0d lat=%0d expected lat=9 q=%0d r=%0d",
                 a, b, quotient, remainder, lat, a / b, a % b);
        end
      end
    end
    start = 1'b0;
    tick();
    chk("exh_end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
